// File: rtl/uart_tx.sv
// UART transmitter: AXI4-Stream byte in, 8N1-style frame out on txd.
// A one-entry hold register lets the next byte load on the last stop cycle, so frames run back-to-back.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       txd,
    output logic       busy
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1..2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 hold_full, hold_full_n;
    logic                 txd_n;
    logic                 last_baud;
    logic                 shifter_free;

    assign s_tready = ~hold_full;
    assign busy     = (state != IDLE) | hold_full;

    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        txd_n       = 1'b1;

        last_baud    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
        shifter_free = (state == IDLE) ||
                       (state == STOP && last_baud && bit_idx == 3'(STOP_BITS - 1));

        unique case (state)
            IDLE: ;
            START: begin
                if (last_baud) begin
                    state_n    = DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (last_baud) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_n   = STOP;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (last_baud) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        state_n   = IDLE;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Load overrides the STOP->IDLE exit so the next start bit follows with no gap.
        if (hold_full && shifter_free) begin
            shift_n     = hold;
            hold_full_n = 1'b0;
            state_n     = START;
            baud_cnt_n  = '0;
            bit_idx_n   = '0;
        end

        // Never coincides with a load: a load needs hold_full, a handshake needs ~hold_full.
        if (s_tvalid && !hold_full) begin
            hold_n      = s_tdata[DATA_BITS-1:0];
            hold_full_n = 1'b1;
        end

        // txd is registered, so it is computed from the next state.
        unique case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            txd       <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            txd       <= txd_n;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: the transmit-side neighbour of the UART receive path.
- Consumes bytes from an AXI4-Stream slave port and serialises each one on the RS-232 TXD line as start bit, data bits (LSB first) and stop bit(s).
- One-entry holding register decouples the stream handshake from the shifter, so consecutive frames go out back-to-back with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8; uses s_tdata[DATA_BITS-1:0].
- STOP_BITS, 1, stop bits per frame; legal 1..2.
- CLKS_PER_BIT, 8, clk cycles per bit period; legal >= 2; elaboration error otherwise.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- s_tdata  input  8  byte to transmit; sampled only on handshake
- s_tvalid  input  1  stream valid
- s_tready  output  1  stream ready
- txd  output  1  serial output; 1 = MARK/idle, 0 = SPACE
- busy  output  1  frame in progress or byte held

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock clk.
  - While resetn=0 at a rising edge: txd=1, s_tready=1, busy=0, state=IDLE, hold cleared, counters zeroed.
  - Reset mid-frame aborts the frame; txd is 1 after that edge and the aborted byte is never resumed.
- Handshake:
  - Transfer occurs on an edge where s_tvalid && s_tready; s_tdata is captured into hold and hold_full is set.
  - s_tready = ~hold_full (purely from registered state; no combinational path from s_tvalid).
- Shifter load: at any edge where hold_full=1 and the shifter is free (IDLE, or last cycle of last stop bit):
  - copy hold into the shift register;
  - clear hold_full;
  - enter START.
  - Latency: handshake at edge E0 -> txd=0 after edge E1 when the shifter was IDLE.
- State machine, all bit-period timing via a baud counter 0..CLKS_PER_BIT-1 (txd is registered):
  - IDLE: txd=1; leave only via a load.
  - START: txd=0 for CLKS_PER_BIT cycles -> DATA, bit index=0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit index. After bit DATA_BITS-1 -> STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, go to START if hold_full (same-edge load), else IDLE.
- Frame length: exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles from txd falling edge to end of stop.
- Back-to-back frames have zero idle cycles between them.
- Hold refill:
  - hold can be refilled while a frame is shifting.
  - Handshake and load never coincide on the same edge, because s_tready=0 whenever hold_full=1.
- busy = (state != IDLE) | hold_full.
- Upper s_tdata bits above DATA_BITS are ignored.
- txd is glitch-free: driven directly from a flop.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with s_tvalid=1 -> txd=1, s_tready=1, busy=0 throughout, no handshake.
  - After release with s_tvalid=0 -> txd stays 1 indefinitely.
- Single byte 0xA5, CLKS_PER_BIT=4:
  - txd falls 1 cycle after the handshake edge.
  - Sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles (40 cycles total).
  - Then txd=1 and busy=0.
- Back-to-back 0x00 then 0xFF with s_tvalid held high:
  - s_tready drops after the 2nd handshake and rises when the 2nd byte loads.
  - 2nd start bit begins the cycle after the 1st frame's last stop cycle (no idle gap).
  - Line output 0,00000000,1,0,11111111,1.
- Backpressure, 5 random bytes with random s_tvalid gaps:
  - Scoreboard decodes txd.
  - All 5 bytes are received in order, none dropped or duplicated.
  - s_tdata changes while s_tready=0 have no effect.
- Reset mid-frame: assert resetn=0 for 1 cycle at cycle 15 of a 0x3C frame with a second byte held -> txd=1, s_tready=1, busy=0 next cycle; neither byte is ever transmitted.
- STOP_BITS=2, DATA_BITS=7, byte 0xFF:
  - Stop level lasts 2*CLKS_PER_BIT cycles.
  - Only 7 data bits are sent; frame length 10*CLKS_PER_BIT.
